// File: rtl/lot_pkg.sv
// lot_pkg: shared helpers and types for the multi-gate lot occupancy counter.
package lot_pkg;
  localparam int MAX_CAPACITY = 255;
  typedef struct packed {
    logic enter;
    logic exit;
  } gate_req_t;
  function automatic logic [5:0] popcount_f(input logic [31:0] v, input int unsigned n);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + ((i < n) ? 6'(v[i]) : 6'd0);
    return c;
  endfunction
endpackage

// File: rtl/lot_grant_arbiter.sv
// lot_grant_arbiter: fixed-priority grant of up to free entry requests, gate 0 first.
module lot_grant_arbiter #(
  parameter int N_GATES = 2,
  parameter int FW = 9
) (
  input  logic [N_GATES-1:0] req,
  input  logic [FW-1:0]      free,
  output logic [N_GATES-1:0] grant,
  output logic [N_GATES-1:0] reject
);
  logic [FW-1:0] w_cnt;
  always_comb begin
    grant = '0;
    reject = '0;
    w_cnt = '0;
    for (int i = 0; i < N_GATES; i++) begin
      grant[i] = req[i] && (w_cnt < free);
      reject[i] = req[i] && !(w_cnt < free);
      w_cnt = w_cnt + (grant[i] ? FW'(1) : FW'(0));
    end
  end
endmodule

// File: rtl/lot_occupancy_counter.sv
// lot_occupancy_counter: N-gate lot occupancy with exit-first space reuse and fixed-priority entry.
// Define LOT_STATS_EN to add total_entries and peak_count statistics outputs.
module lot_occupancy_counter
  import lot_pkg::*;
#(
  parameter int N_GATES = 2,
  parameter int CAPACITY = 25,
  parameter int ALMOST_THRESH = 20,
  parameter int CW = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_GATES-1:0] enter_req,
  input  logic [N_GATES-1:0] exit_req,
  output logic [N_GATES-1:0] enter_grant,
  output logic [N_GATES-1:0] enter_reject,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               underflow_err
`ifdef LOT_STATS_EN
  , output logic [15:0]      total_entries
  , output logic [CW-1:0]    peak_count
`endif
);
  // arithmetic width covers both the widest popcount and count plus headroom
  localparam int AW = (CW + 1 > 6) ? CW + 1 : 6;
  logic [CW-1:0]      r_count;
  logic               r_full, r_empty, r_almost, r_uf;
  logic [N_GATES-1:0] r_grant, r_reject;
  logic [N_GATES-1:0] w_grant, w_reject;
  logic [AW-1:0]      w_e, w_cnt, w_xa, w_free, w_na, w_next;
  assign w_cnt  = AW'(r_count);
  assign w_e    = AW'(popcount_f(32'(exit_req), N_GATES));
  assign w_xa   = (w_e > w_cnt) ? w_cnt : w_e;
  assign w_free = AW'(CAPACITY) - w_cnt + w_xa;
  assign w_na   = AW'(popcount_f(32'(w_grant), N_GATES));
  assign w_next = w_cnt - w_xa + w_na;
  lot_grant_arbiter #(.N_GATES(N_GATES), .FW(AW)) u_arb (
    .req(enter_req),
    .free(w_free),
    .grant(w_grant),
    .reject(w_reject)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_full <= 1'b0;
      r_empty <= 1'b1;
      r_almost <= (ALMOST_THRESH == 0);
      r_grant <= '0;
      r_reject <= '0;
      r_uf <= 1'b0;
    end else begin
      r_count <= CW'(w_next);
      r_full <= (w_next == AW'(CAPACITY));
      r_empty <= (w_next == '0);
      r_almost <= (w_next >= AW'(ALMOST_THRESH));
      r_grant <= w_grant;
      r_reject <= w_reject;
      r_uf <= r_uf || (w_e > w_cnt);
    end
  end
  assign count = r_count;
  assign full = r_full;
  assign empty = r_empty;
  assign almost_full = r_almost;
  assign enter_grant = r_grant;
  assign enter_reject = r_reject;
  assign underflow_err = r_uf;
`ifdef LOT_STATS_EN
  logic [15:0]   r_total;
  logic [CW-1:0] r_peak;
  logic [16:0]   w_sum;
  assign w_sum = 17'(r_total) + 17'(w_na);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_total <= '0;
      r_peak <= '0;
    end else begin
      r_total <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      r_peak <= (CW'(w_next) > r_peak) ? CW'(w_next) : r_peak;
    end
  end
  assign total_entries = r_total;
  assign peak_count = r_peak;
`endif
endmodule

// File: tb/tb_lot_occupancy_counter.sv
// tb_lot_occupancy_counter: directed plan scenarios plus random traffic against a behavioural model.
module tb_lot_occupancy_counter;
  import lot_pkg::*;
  localparam int N = 2;
  localparam int CAP = 5;
  localparam int AT = 4;
  localparam int CW = $clog2(CAP + 1);
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] enter_req = '0, exit_req = '0;
  logic [N-1:0] enter_grant, enter_reject;
  logic [CW-1:0] count;
  logic full, empty, almost_full, underflow_err;
`ifdef LOT_STATS_EN
  logic [15:0] total_entries;
  logic [CW-1:0] peak_count;
`endif
  int tests = 0, fails = 0;
  int m_count = 0, m_uf = 0, m_tot = 0, m_peak = 0;
  logic [N-1:0] m_g = '0, m_r = '0;
  gate_req_t g [N];
  always #5 clk = ~clk;
  lot_occupancy_counter #(.N_GATES(N), .CAPACITY(CAP), .ALMOST_THRESH(AT)) dut (
    .clk(clk), .reset(reset), .enter_req(enter_req), .exit_req(exit_req),
    .enter_grant(enter_grant), .enter_reject(enter_reject), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .underflow_err(underflow_err)
`ifdef LOT_STATS_EN
    , .total_entries(total_entries), .peak_count(peak_count)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [N-1:0] en, input logic [N-1:0] ex, input bit rst);
    int e, xa, free, k;
    enter_req = en;
    exit_req = ex;
    reset = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      m_count = 0; m_uf = 0; m_g = '0; m_r = '0; m_tot = 0; m_peak = 0;
    end else begin
      e = $countones(ex);
      xa = (e < m_count) ? e : m_count;
      if (e > m_count) m_uf = 1;
      free = CAP - m_count + xa;
      k = 0; m_g = '0; m_r = '0;
      for (int i = 0; i < N; i++)
        if (en[i]) begin
          if (k < free) begin m_g[i] = 1'b1; k++; end
          else m_r[i] = 1'b1;
        end
      m_count = m_count - xa + k;
      m_tot = (m_tot + k > 65535) ? 65535 : m_tot + k;
      if (m_count > m_peak) m_peak = m_count;
    end
    chk("count", 32'(count), 32'(m_count));
    chk("full", 32'(full), 32'(m_count == CAP));
    chk("empty", 32'(empty), 32'(m_count == 0));
    chk("almost", 32'(almost_full), 32'(m_count >= AT));
    chk("grant", 32'(enter_grant), 32'(m_g));
    chk("reject", 32'(enter_reject), 32'(m_r));
    chk("underflow", 32'(underflow_err), 32'(m_uf));
`ifdef LOT_STATS_EN
    chk("total", 32'(total_entries), 32'(m_tot));
    chk("peak", 32'(peak_count), 32'(m_peak));
`endif
  endtask
  initial begin
    step(2'b00, 2'b00, 1);
    repeat (3) step(2'b00, 2'b00, 0);
    chk("plan_rst_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(2'b01, 2'b00, 0);
      chk("plan_step", 32'(count), 32'(i + 1));
    end
    chk("plan_full5", 32'(full), 32'd1);
    step(2'b01, 2'b00, 0);
    chk("plan_rej6", 32'(enter_reject), 32'b01);
    step(2'b00, 2'b01, 0);
    step(2'b11, 2'b00, 0);
    chk("plan_pri_grant", 32'(enter_grant), 32'b01);
    chk("plan_pri_reject", 32'(enter_reject), 32'b10);
    step(2'b10, 2'b01, 0);
    chk("plan_reuse", 32'(enter_grant), 32'b10);
    chk("plan_reuse_cnt", 32'(count), 32'd5);
    step(2'b00, 2'b11, 0);
    step(2'b00, 2'b01, 0);
    step(2'b00, 2'b01, 0);
    step(2'b00, 2'b11, 0);
    chk("plan_uf", 32'(underflow_err), 32'd1);
    step(2'b11, 2'b00, 0);
    step(2'b01, 2'b01, 0);
    chk("plan_uf_sticky", 32'(underflow_err), 32'd1);
    step(2'b11, 2'b00, 1);
    chk("plan_rst_grant", 32'(enter_grant), 32'd0);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        g[i].enter = ($urandom_range(0, 99) < 55);
        g[i].exit = ($urandom_range(0, 99) < 40);
      end
      step({g[1].enter, g[0].enter}, {g[1].exit, g[0].exit}, ($urandom_range(0, 49) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lot_occupancy_counter.md
Name: lot_occupancy_counter

Overview:
- Parametrised successor to the single-gate lot counter.
- Tracks occupancy of one parking lot served by N_GATES independent entry/exit gates, with a configurable capacity.
- Accepts simultaneous entries and exits, arbitrates scarce spaces among entry gates by fixed priority, and reports full, empty and almost-full plus per-gate grant and reject.
- Sits between the gate sensor/debounce logic and the display/HEX driver.

Parameters:
N_GATES, 2, number of gates; each gate has one entry request and one exit request.
CAPACITY, 25, maximum occupancy; legal range 1..255.
ALMOST_THRESH, 20, almost_full asserts when count >= ALMOST_THRESH; must be <= CAPACITY.
CW, $clog2(CAPACITY+1), count width (derived; not overridden).

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enter_req  in  N_GATES  one-cycle pulse per car arriving at gate i
exit_req  in  N_GATES  one-cycle pulse per car leaving at gate i
enter_grant  out  N_GATES  registered; bit i high one cycle after gate i's entry is accepted
enter_reject  out  N_GATES  registered; bit i high one cycle after gate i's entry is refused (lot full)
count  out  CW  registered current occupancy
full  out  1  registered; count == CAPACITY
empty  out  1  registered; count == 0
almost_full  out  1  registered; count >= ALMOST_THRESH
underflow_err  out  1  sticky; set when an exit arrives while no car is available to leave

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: count = 0, empty = 1, full = 0, almost_full = 0 (or 1 if ALMOST_THRESH == 0), enter_grant = 0, enter_reject = 0, underflow_err = 0.
- Reset has priority over all requests. Requests in the reset cycle are dropped, with no grant and no reject.
- Each cycle, request vectors are evaluated combinationally from the current registered count. All outputs update at the next posedge (latency 1).
- Step 1, exits: E = popcount(exit_req).
  - Accepted exits Xa = min(E, count).
  - If E > count, underflow_err sets and stays set until reset.
  - Surplus exits are discarded.
- Step 2, entries: space freed by exits in the same cycle is usable.
  - Free = CAPACITY - count + Xa.
  - Gates are scanned from index 0 upward. Each requesting gate is granted while granted-so-far < Free; remaining requesting gates are rejected.
  - Na = number of granted gates.
- count_next = count - Xa + Na, computed at CW+1 bits so no intermediate wrap occurs. Result is always in 0..CAPACITY; there is no wrap-around.
- Flags full, empty and almost_full derive from count_next and register with it. They are always consistent with count on the same cycle.
- enter_grant and enter_reject are mutually exclusive per bit. Both are 0 for a gate that did not request.
- The same gate may request entry and exit in one cycle; they are counted independently.
- Quiet cycle (no requests): count and flags hold; grant and reject outputs go to 0.
- No state machine beyond the occupancy register and the sticky error. A cycle-based design is used in place of an FSM.

Optional Feature:
Macro LOT_STATS_EN.
- Defined: adds output total_entries [15:0] and output peak_count [CW-1:0], both reset to 0.
  - total_entries += Na each cycle, saturating at 16'hFFFF.
  - peak_count is updated to count_next whenever count_next > peak_count.
  - Both are registered with count.
- Undefined: neither port exists, and the logic is absent.

Decomposition:
- Package lot_pkg holds:
  - function popcount_f (generic over a 32-bit input, masked);
  - localparam MAX_CAPACITY = 255;
  - typedef struct gate_req_t {enter, exit}, for bench use.
- One sub-module, lot_grant_arbiter: combinational fixed-priority grant of up to Free requests among N_GATES. Inputs are req and free; outputs are grant and reject.
- The top module holds all registers.

Test Plan:
- Reset, then no requests for 3 cycles -> count = 0, empty = 1, full = 0, all grants 0, underflow_err = 0.
- With N_GATES = 2, CAPACITY = 5, ALMOST_THRESH = 4: single entries on gate 0 over 5 cycles -> count steps 1..5 one cycle after each request; almost_full rises at 4; full rises at 5. A 6th request -> enter_reject[0] = 1, count stays 5.
- count = 4, enter_req = 2'b11 in the same cycle -> enter_grant = 2'b01, enter_reject = 2'b10, count = 5, full = 1.
- count = 5, exit_req = 2'b01 and enter_req = 2'b10 in the same cycle -> freed space reused: enter_grant = 2'b10, count stays 5, full stays 1.
- count = 1, exit_req = 2'b11 -> count = 0, empty = 1, underflow_err = 1. The error stays 1 after further legal traffic until reset.
- Reset asserted mid-traffic with enter_req = 2'b11 -> next cycle count = 0 and no grant. With LOT_STATS_EN defined, total_entries and peak_count also return to 0; before that reset, peak_count equals the highest count reached.
